alu_issue: RTL and testbench

Initiator-side sequencer for the datapath ALU. It accepts one operation request through a valid/ready handshake and drives the ALU's `ctrl`, `A`, `B` and `enable` inputs. It holds them stable for the operation's latency, captures `zHI`/`zLOW` and returns the result through a valid/ready response channel. It sits between the control unit and the ALU, replacing direct combinational drive of the ALU select lines.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_issue_if.sv | 42 ++++
 rtl/alu_issue_lat.sv | 50 +++++
 rtl/alu_issue.sv | 142 ++++++++++++++
 tb/tb_alu_issue.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcode constants and issue-sequencer state encoding shared by the
//           ALU and alu_issue.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [4:0] OP_ADD        = 5'd0;
  localparam logic [4:0] OP_SUB        = 5'd1;
  localparam logic [4:0] OP_MUL        = 5'd2;
  localparam logic [4:0] OP_DIV        = 5'd3;
  localparam logic [4:0] OP_SHR        = 5'd4;
  localparam logic [4:0] OP_SHL        = 5'd5;
  localparam logic [4:0] OP_ROR        = 5'd6;
  localparam logic [4:0] OP_ROL        = 5'd7;
  localparam logic [4:0] OP_AND        = 5'd8;
  localparam logic [4:0] OP_OR         = 5'd9;
  localparam logic [4:0] OP_NEG        = 5'd10;
  localparam logic [4:0] OP_NOT        = 5'd11;
  localparam logic [4:0] OP_LAST_LEGAL = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [4:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_if.sv
// ============================================================================
// Module  : alu_issue_if
// Brief   : Request, ALU-drive and response signals of the ALU issue sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_issue_if;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_enable;
  logic [31:0] alu_zhi;
  logic [31:0] alu_zlow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;

  // Requester/ALU side (control unit plus the ALU itself)
  modport master (
    output req_valid, req_op, req_a, req_b, alu_zhi, alu_zlow, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, alu_enable,
    input  rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_zhi, alu_zlow, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, alu_enable,
    output rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/alu_issue_lat.sv
// ============================================================================
// Module  : alu_issue_lat
// Brief   : Maps an opcode to its execute latency and counts it down.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_lat
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 1,
  parameter int CW      = 8
) (
  input  wire logic       clk,
  input  wire logic       clr,
  input  wire logic       load,
  input  wire logic [4:0] op,
  output logic            done,
  output logic            busy
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_lat;

  always_comb begin
    w_lat = CW'(1);
    case (op)
      OP_MUL:  w_lat = CW'(MUL_LAT);
      OP_DIV:  w_lat = CW'(DIV_LAT);
      default: w_lat = CW'(1);
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= w_lat;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign done = (r_cnt == CW'(1));
  assign busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// ============================================================================
// Module  : alu_issue
// Brief   : Sequences one ALU operation per request and returns zHI/zLOW.
//           Optional: ALU_ISSUE_DIVZERO_CHECK_EN rejects divide-by-zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 1
) (
  input  wire logic   clk,
  input  wire logic   clr,
  alu_issue_if.slave  bus
);

  state_t      r_state;
  state_t      w_next;
  logic        w_load;
  logic        w_cap;
  logic        w_rej;
  logic        w_divzero;
  logic        w_req_ready;
  logic        w_alu_enable;
  logic        w_rsp_valid;
  logic        w_done;
  logic        w_busy;
  logic [4:0]  r_ctrl;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_err;

  alu_issue_lat #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_lat (
    .clk  (clk),
    .clr  (clr),
    .load (w_load),
    .op   (bus.req_op),
    .done (w_done),
    .busy (w_busy)
  );

`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
  assign w_divzero = (bus.req_op == OP_DIV) && (bus.req_b == 32'd0);
`else
  assign w_divzero = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_cap        = 1'b0;
    w_rej        = 1'b0;
    w_req_ready  = 1'b0;
    w_alu_enable = 1'b0;
    w_rsp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!op_is_legal(bus.req_op) || w_divzero) begin
            w_rej  = 1'b1;
            w_next = ST_RESP;
          end else begin
            w_load = 1'b1;
            w_next = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        w_alu_enable = w_busy;
        if (w_done) begin
          w_cap  = 1'b1;
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Rejected divide-by-zero reports A in hi and all-ones in lo; other rejects report zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ctrl <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_ctrl <= bus.req_op;
        r_a    <= bus.req_a;
        r_b    <= bus.req_b;
      end
      if (w_cap) begin
        r_hi  <= bus.alu_zhi;
        r_lo  <= bus.alu_zlow;
        r_err <= 1'b0;
      end else if (w_rej) begin
        r_hi  <= w_divzero ? bus.req_a : 32'd0;
        r_lo  <= w_divzero ? 32'hFFFF_FFFF : 32'd0;
        r_err <= 1'b1;
      end
    end
  end

  // req_ready follows clr combinationally so it is low for the whole reset.
  assign bus.req_ready  = w_req_ready & ~clr;
  assign bus.alu_enable = w_alu_enable;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.alu_ctrl   = r_ctrl;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.rsp_hi     = r_hi;
  assign bus.rsp_lo     = r_lo;
  assign bus.rsp_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// Module  : tb_alu_issue
// Brief   : Scoreboard bench for alu_issue with a behavioural ALU attached.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  rsp_t exp_q[$];

  alu_issue_if bus();

  alu_issue #(.MUL_LAT(2), .DIV_LAT(1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; division by zero returns hi=A, lo=all-ones
  logic [63:0] prod;
  always_comb begin
    prod         = {32'd0, bus.alu_a} * {32'd0, bus.alu_b};
    bus.alu_zhi  = 32'd0;
    bus.alu_zlow = 32'd0;
    case (bus.alu_ctrl)
      OP_ADD: bus.alu_zlow = bus.alu_a + bus.alu_b;
      OP_SUB: bus.alu_zlow = bus.alu_a - bus.alu_b;
      OP_MUL: begin bus.alu_zhi = prod[63:32]; bus.alu_zlow = prod[31:0]; end
      OP_DIV: begin
        if (bus.alu_b == 32'd0) begin
          bus.alu_zhi  = bus.alu_a;
          bus.alu_zlow = 32'hFFFF_FFFF;
        end else begin
          bus.alu_zhi  = bus.alu_a % bus.alu_b;
          bus.alu_zlow = bus.alu_a / bus.alu_b;
        end
      end
      OP_SHR: bus.alu_zlow = bus.alu_a >> bus.alu_b[4:0];
      OP_SHL: bus.alu_zlow = bus.alu_a << bus.alu_b[4:0];
      OP_ROR: bus.alu_zlow = (bus.alu_a >> bus.alu_b[4:0]) | (bus.alu_a << (6'd32 - {1'b0, bus.alu_b[4:0]}));
      OP_ROL: bus.alu_zlow = (bus.alu_a << bus.alu_b[4:0]) | (bus.alu_a >> (6'd32 - {1'b0, bus.alu_b[4:0]}));
      OP_AND: bus.alu_zlow = bus.alu_a & bus.alu_b;
      OP_OR:  bus.alu_zlow = bus.alu_a | bus.alu_b;
      OP_NEG: bus.alu_zlow = -bus.alu_a;
      OP_NOT: bus.alu_zlow = ~bus.alu_a;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed response is matched against the scoreboard head
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got hi=%h lo=%h err=%b expected none",
                 bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp", {31'd0, bus.rsp_hi, bus.rsp_lo, bus.rsp_err}, {31'd0, e.hi, e.lo, e.err});
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int t;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready && t < 50);
    if (!bus.req_ready) chk("req_accept_timeout", 96'd0, 96'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts alu_enable cycles after the handshake and the cycle rsp_valid rises
  task automatic wait_rsp(input string name, input int exp_en);
    int k, en;
    k = 0;
    en = 0;
    do begin
      @(negedge clk);
      k++;
      if (!bus.rsp_valid && bus.alu_enable) en++;
    end while (!bus.rsp_valid && k < 50);
    chk({name, "_timing"}, {32'd0, 32'(en), 32'(k)}, {32'd0, 32'(exp_en), 32'(exp_en + 1)});
  endtask

  task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input logic err, input int exp_en);
    rsp_t e;
    e.hi = hi; e.lo = lo; e.err = err;
    exp_q.push_back(e);
    send(op, a, b);
    wait_rsp(name, exp_en);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 5'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_outs", {32'd0, 27'd0, bus.req_ready, bus.rsp_valid, bus.alu_enable, bus.alu_ctrl,
                       bus.rsp_lo}, 96'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {95'd0, bus.req_ready}, 96'd1);

    issue("add",  OP_ADD, 32'd5, 32'd3, 32'd0, 32'd8, 1'b0, 1);
    issue("mul",  OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 2);
    issue("mul2", OP_MUL, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 2);
    issue("div",  OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
    issue("shr",  OP_SHR, 32'h80, 32'd3, 32'd0, 32'h10, 1'b0, 1);
    issue("rol",  OP_ROL, 32'h8000_0001, 32'd1, 32'd0, 32'h3, 1'b0, 1);
    issue("neg",  OP_NEG, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    issue("not",  OP_NOT, 32'h0F0F_0F0F, 32'd0, 32'd0, 32'hF0F0_F0F0, 1'b0, 1);
    issue("sub",  OP_SUB, 32'd10, 32'd3, 32'd0, 32'd7, 1'b0, 1);
    @(negedge clk);
    chk("hold_alu_inputs", {54'd0, bus.alu_enable, bus.alu_ctrl, bus.alu_a[7:0], bus.alu_b[27:0]},
        {54'd0, 1'b0, OP_SUB, 8'd10, 28'd3});
    issue("illegal20", 5'd20, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 0);
    issue("illegal12", 5'd12, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 0);
    issue("illegal31", 5'd31, 32'd1, 32'd1, 32'd0, 32'd0, 1'b1, 0);
    @(negedge clk);
    chk("illegal_keeps_ctrl", {91'd0, bus.alu_ctrl}, {91'd0, OP_SUB});
`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
    issue("divzero", OP_DIV, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 0);
`else
    issue("divzero", OP_DIV, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0, 1);
`endif

    // Backpressure: hold rsp_ready low while a second request waits
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    issue("bp_add", OP_ADD, 32'd10, 32'd20, 32'd0, 32'd30, 1'b0, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_OR;
    bus.req_a     = 32'hF0;
    bus.req_b     = 32'h0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_err, 29'd0, bus.rsp_hi, bus.rsp_lo},
          {1'b1, 1'b0, 1'b0, 29'd0, 32'd0, 32'd30});
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_not_yet", {95'd0, bus.req_ready}, 96'd0);
    @(negedge clk);
    chk("bp_ready_after", {94'd0, bus.req_ready, bus.alu_enable}, {94'd0, 1'b1, 1'b0});
    begin
      rsp_t e;
      e.hi = 32'd0; e.lo = 32'hFF; e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_rsp("bp_or", 1);

    // Reset during the execute phase of a multiply
    send(OP_MUL, 32'd6, 32'd7);
    @(negedge clk);
    chk("mul_exec", {95'd0, bus.alu_enable}, 96'd1);
    #1;
    clr = 1'b1;
    #1;
    chk("reset_mid", {93'd0, bus.alu_enable, bus.rsp_valid, bus.req_ready}, 96'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    clr = 1'b0;
    issue("post_reset_add", OP_ADD, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
